mips_mem_sequencer: RTL

Multi-cycle control sequencer placed beside `mips_decode`. It shares a single memory port between instruction fetch and data access (`lw`, `lbu`, `sw`, `sb`, `addm`), waiting on a ready handshake for each. It emits the per-cycle write strobes for the instruction register, register file and PC. It also counts retired instructions and detects memory timeouts.

---
 rtl/mips_mem_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/mips_mem_sequencer.sv
// mips_mem_sequencer: multi-cycle fetch/decode/mem/writeback sequencer sharing one memory port,
// with a per-access wait counter that halts on timeout and a retired-instruction counter.
module mips_mem_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4,
    parameter int CW      = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mem_ready,
    input  logic          writeenable,
    input  logic          except,
    input  logic          mem_read,
    input  logic          word_we,
    input  logic          byte_we,
    input  logic          addm,
    output logic          mem_req,
    output logic          mem_addr_sel,
    output logic          mem_write,
    output logic          inst_we,
    output logic          reg_we,
    output logic          pc_we,
    output logic          exc_pulse,
    output logic          bus_error,
    output logic [2:0]    state,
    output logic [CW-1:0] retired
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        WB     = 3'd3,
        EXC    = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [CW-1:0] retired_q;
    logic          bus_error_q;
    logic          timeout;

    assign timeout = wait_q == TW'(TIMEOUT);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            FETCH, MEM: begin
                if (mem_ready) state_d = (state_q == FETCH) ? DECODE : WB;
                else if (timeout) state_d = HALT;
                else wait_d = wait_q + TW'(1);
            end
            DECODE: begin
                state_d = except ? EXC : (mem_read | word_we | byte_we | addm) ? MEM : WB;
                wait_d  = '0;
            end
            WB, EXC: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            wait_q      <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == WB) retired_q <= retired_q + CW'(1);
            if (state_d == HALT) bus_error_q <= 1'b1;
        end
    end

    // Strobes are gated by reset so an asserted reset silences them immediately.
    assign mem_req      = reset & (state_q == FETCH || state_q == MEM);
    assign mem_addr_sel = state_q == MEM;
    assign mem_write    = reset & (state_q == MEM) & (word_we | byte_we);
    assign inst_we      = reset & (state_q == FETCH) & mem_ready;
    assign reg_we       = reset & (state_q == WB) & writeenable;
    assign pc_we        = reset & (state_q == WB || state_q == EXC);
    assign exc_pulse    = reset & (state_q == EXC);
    assign bus_error    = bus_error_q;
    assign state        = state_q;
    assign retired      = retired_q;
endmodule
